// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 8-requester operand-bus arbiter:
// FSM state encoding, requester/select sizing and the round-robin pick.
package bus_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Search upward from the slot after the last owner, wrapping at NUM_REQ,
    // so the previous owner is always considered last.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [SEL_W-1:0]   last);
        rr_pick_t         res;
        logic [SEL_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = {SEL_W{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + SEL_W'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_16w_8_to_1.sv
// WIDTH-bit combinational 8:1 mux; {S2,S1,S0} selects R (0) through Y (7).
module mux_16w_8_to_1 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    input  logic [WIDTH-1:0] U,
    input  logic [WIDTH-1:0] V,
    input  logic [WIDTH-1:0] W,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    output logic [WIDTH-1:0] M
);

    // Route the selected requester word to the output.
    always_comb begin
        M = {WIDTH{1'b0}};
        case ({S2, S1, S0})
            3'd0:    M = R;
            3'd1:    M = S;
            3'd2:    M = T;
            3'd3:    M = U;
            3'd4:    M = V;
            3'd5:    M = W;
            3'd6:    M = X;
            3'd7:    M = Y;
            default: M = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter/sequencer for the shared 8-to-1 operand bus.
// Grants one requester at a time for at most MAX_HOLD cycles, inserts a
// dead TURN cycle plus an IDLE arbitration cycle between grants, and
// registers the selected word onto the bus with a valid flag.
module bus_arbiter_8
    import bus_arb_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [WIDTH-1:0]   In0,
    input  logic [WIDTH-1:0]   In1,
    input  logic [WIDTH-1:0]   In2,
    input  logic [WIDTH-1:0]   In3,
    input  logic [WIDTH-1:0]   In4,
    input  logic [WIDTH-1:0]   In5,
    input  logic [WIDTH-1:0]   In6,
    input  logic [WIDTH-1:0]   In7,
    output logic [NUM_REQ-1:0] Grant,
    output logic               S2,
    output logic               S1,
    output logic               S0,
    output logic [WIDTH-1:0]   DataOut,
    output logic               DataValid,
    output logic               Expired
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_e          state_r,   state_nxt_s;
    logic [NUM_REQ-1:0]  grant_r,   grant_nxt_s;
    logic [SEL_W-1:0]    sel_r,     sel_nxt_s;
    logic [SEL_W-1:0]    last_r,    last_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_nxt_s;
    logic                expired_r, expired_nxt_s;
    logic [WIDTH-1:0]    data_out_r;
    logic                data_valid_r;
    logic [WIDTH-1:0]    mux_out_s;
    rr_pick_t            pick_s;

    assign pick_s = rr_pick(Req, last_r);

    // Select lines come from the registered owner index, so the only
    // combinational path is In* through the mux into the DataOut register.
    mux_16w_8_to_1 #(.WIDTH(WIDTH)) u_mux (
        .R (In0), .S (In1), .T (In2), .U (In3),
        .V (In4), .W (In5), .X (In6), .Y (In7),
        .S0(sel_r[0]), .S1(sel_r[1]), .S2(sel_r[2]),
        .M (mux_out_s)
    );

    // FSM and arbitration registers.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r    <= IDLE;
            grant_r    <= {NUM_REQ{1'b0}};
            sel_r      <= {SEL_W{1'b0}};
            last_r     <= 3'd7;
            hold_cnt_r <= {HOLD_W{1'b0}};
            expired_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            sel_r      <= sel_nxt_s;
            last_r     <= last_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            expired_r  <= expired_nxt_s;
        end
    end

    // Next-state logic; other requesters are ignored while a grant is held.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        sel_nxt_s     = sel_r;
        last_nxt_s    = last_r;
        hold_nxt_s    = hold_cnt_r;
        expired_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s.found) begin
                    state_nxt_s = GRANT;
                    grant_nxt_s = 8'b0000_0001 << pick_s.idx;
                    sel_nxt_s   = pick_s.idx;
                    hold_nxt_s  = HOLD_W'(1);
                end else begin
                    grant_nxt_s = {NUM_REQ{1'b0}};
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end
            end
            GRANT: begin
                if (!Req[sel_r]) begin
                    state_nxt_s = TURN;
                    grant_nxt_s = {NUM_REQ{1'b0}};
                    last_nxt_s  = sel_r;
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end else if (hold_cnt_r >= HOLD_W'(MAX_HOLD)) begin
                    state_nxt_s   = TURN;
                    grant_nxt_s   = {NUM_REQ{1'b0}};
                    last_nxt_s    = sel_r;
                    hold_nxt_s    = {HOLD_W{1'b0}};
                    expired_nxt_s = 1'b1;
                end else begin
                    hold_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            TURN: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {NUM_REQ{1'b0}};
                hold_nxt_s  = {HOLD_W{1'b0}};
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {NUM_REQ{1'b0}};
                hold_nxt_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Capture the owner's word on every edge spent in GRANT; hold otherwise.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
        end else if (state_r == GRANT) begin
            data_out_r   <= mux_out_s;
            data_valid_r <= 1'b1;
        end else begin
            data_out_r   <= data_out_r;
            data_valid_r <= 1'b0;
        end
    end

    assign Grant     = grant_r;
    assign S2        = sel_r[2];
    assign S1        = sel_r[1];
    assign S0        = sel_r[0];
    assign DataOut   = data_out_r;
    assign DataValid = data_valid_r;
    assign Expired   = expired_r;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed self-checking bench for bus_arbiter_8 (MAX_HOLD = 8).
module tb_bus_arbiter_8;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic [7:0]  Req = 8'h00;
    logic [15:0] in_w [0:7];
    logic [7:0]  Grant;
    logic        S2, S1, S0;
    logic [15:0] DataOut;
    logic        DataValid, Expired;
    logic [2:0]  sel_w;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign sel_w = {S2, S1, S0};

    bus_arbiter_8 #(.WIDTH(16), .MAX_HOLD(8)) dut (
        .Clock(Clock), .ResetN(ResetN), .Req(Req),
        .In0(in_w[0]), .In1(in_w[1]), .In2(in_w[2]), .In3(in_w[3]),
        .In4(in_w[4]), .In5(in_w[5]), .In6(in_w[6]), .In7(in_w[7]),
        .Grant(Grant), .S2(S2), .S1(S1), .S0(S0),
        .DataOut(DataOut), .DataValid(DataValid), .Expired(Expired)
    );

    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic reset_pulse;
        ResetN = 1'b0;
        #2;
        ResetN = 1'b1;
    endtask

    task automatic test_reset;
        ResetN = 1'b0;
        Req    = 8'h00;
        tick;
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h expected %h", {Grant, sel_w, DataValid, Expired}, 13'h0);
        end
        n_checks++;
        if (DataOut !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected %h", DataOut, 16'h0000);
        end
        ResetN = 1'b1;
        tick;
    endtask

    task automatic test_single;
        logic [12:0] exp_t [0:4];
        exp_t[0] = {8'h01, 3'd0, 1'b0, 1'b0};
        exp_t[1] = {8'h01, 3'd0, 1'b1, 1'b0};
        exp_t[2] = {8'h01, 3'd0, 1'b1, 1'b0};
        exp_t[3] = {8'h00, 3'd0, 1'b1, 1'b0};
        exp_t[4] = {8'h00, 3'd0, 1'b0, 1'b0};
        Req = 8'h01;
        for (int c = 0; c < 5; c++) begin
            tick;
            n_checks++;
            if ({Grant, sel_w, DataValid, Expired} !== exp_t[c]) begin
                n_fail++;
                $display("FAIL single_c%0d: got %h expected %h", c, {Grant, sel_w, DataValid, Expired}, exp_t[c]);
            end
            if (exp_t[c][1]) begin
                n_checks++;
                if (DataOut !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL single_data_c%0d: got %h expected %h", c, DataOut, 16'h1234);
                end
            end
            if (c == 2) Req = 8'h00;
        end
    endtask

    task automatic test_max_hold;
        logic [12:0] exp_v;
        logic [2:0]  idx;
        logic        vld;
        reset_pulse;
        Req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            idx = 3'(g % 8);
            for (int j = 0; j < 10; j++) begin
                tick;
                vld   = (j >= 1) && (j <= 8);
                exp_v = {((j < 8) ? (8'h01 << idx) : 8'h00), idx, vld, (j == 8)};
                n_checks++;
                if ({Grant, sel_w, DataValid, Expired} !== exp_v) begin
                    n_fail++;
                    $display("FAIL maxhold_g%0d_j%0d: got %h expected %h", g, j, {Grant, sel_w, DataValid, Expired}, exp_v);
                end
                if (vld) begin
                    n_checks++;
                    if (DataOut !== in_w[idx]) begin
                        n_fail++;
                        $display("FAIL maxhold_data_g%0d_j%0d: got %h expected %h", g, j, DataOut, in_w[idx]);
                    end
                end
            end
        end
        Req = 8'h00;
        tick;
    endtask

    task automatic test_owner_switch;
        reset_pulse;
        Req = 8'h20;
        tick;
        n_checks++;
        if ({Grant, sel_w} !== {8'h20, 3'd5}) begin
            n_fail++;
            $display("FAIL owner5_grant: got %h expected %h", {Grant, sel_w}, {8'h20, 3'd5});
        end
        tick;
        Req = 8'h24;
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== {8'h20, 3'd5, 1'b1, 1'b0} || DataOut !== 16'h5555) begin
            n_fail++;
            $display("FAIL owner5_ignore: got %h/%h expected %h/%h", {Grant, sel_w, DataValid, Expired}, DataOut, {8'h20, 3'd5, 1'b1, 1'b0}, 16'h5555);
        end
        Req = 8'h04;
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== {8'h00, 3'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL owner5_turn: got %h expected %h", {Grant, sel_w, DataValid, Expired}, {8'h00, 3'd5, 1'b1, 1'b0});
        end
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== {8'h00, 3'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL owner5_idle: got %h expected %h", {Grant, sel_w, DataValid, Expired}, {8'h00, 3'd5, 1'b0, 1'b0});
        end
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== {8'h04, 3'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL owner2_grant: got %h expected %h", {Grant, sel_w, DataValid, Expired}, {8'h04, 3'd2, 1'b0, 1'b0});
        end
        Req = 8'h00;
        tick;
        tick;
    endtask

    task automatic test_wraparound;
        Req = 8'h40;
        tick;
        n_checks++;
        if ({Grant, sel_w} !== {8'h40, 3'd6}) begin
            n_fail++;
            $display("FAIL wrap_setup: got %h expected %h", {Grant, sel_w}, {8'h40, 3'd6});
        end
        Req = 8'h00;
        tick;
        tick;
        Req = 8'h41;
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== {8'h01, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_first: got %h expected %h", {Grant, sel_w, DataValid, Expired}, {8'h01, 3'd0, 1'b0, 1'b0});
        end
        Req = 8'h40;
        tick;
        tick;
        n_checks++;
        if ({Grant, DataValid} !== {8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_gap: got %h expected %h", {Grant, DataValid}, {8'h00, 1'b0});
        end
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== {8'h40, 3'd6, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_second: got %h expected %h", {Grant, sel_w, DataValid, Expired}, {8'h40, 3'd6, 1'b0, 1'b0});
        end
        Req = 8'h00;
        tick;
        tick;
    endtask

    task automatic test_reset_mid_grant;
        Req = 8'h08;
        tick;
        n_checks++;
        if ({Grant, sel_w} !== {8'h08, 3'd3}) begin
            n_fail++;
            $display("FAIL rstmid_grant: got %h expected %h", {Grant, sel_w}, {8'h08, 3'd3});
        end
        tick;
        tick;
        n_checks++;
        if ({DataValid, DataOut} !== {1'b1, 16'h3333}) begin
            n_fail++;
            $display("FAIL rstmid_data: got %h expected %h", {DataValid, DataOut}, {1'b1, 16'h3333});
        end
        #3;
        ResetN = 1'b0;
        #1;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired, DataOut} !== 29'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h expected %h", {Grant, sel_w, DataValid, Expired, DataOut}, 29'h0);
        end
        Req = 8'h09;
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        tick;
        n_checks++;
        if ({Grant, sel_w, DataValid, Expired} !== {8'h01, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_after: got %h expected %h", {Grant, sel_w, DataValid, Expired}, {8'h01, 3'd0, 1'b0, 1'b0});
        end
        Req = 8'h00;
        tick;
        tick;
    endtask

    task automatic test_idle;
        Req = 8'h00;
        tick;
        tick;
        tick;
        for (int c = 0; c < 20; c++) begin
            tick;
            n_checks++;
            if ({Grant, DataValid, Expired} !== 10'h0) begin
                n_fail++;
                $display("FAIL idle_c%0d: got %h expected %h", c, {Grant, DataValid, Expired}, 10'h0);
            end
        end
        Req = 8'h02;
        tick;
        n_checks++;
        if ({Grant, sel_w} !== {8'h02, 3'd1}) begin
            n_fail++;
            $display("FAIL idle_exit: got %h expected %h", {Grant, sel_w}, {8'h02, 3'd1});
        end
        Req = 8'h00;
        tick;
        tick;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            in_w[i] = (i == 0) ? 16'h1234 : 16'(i * 16'h1111);
        end
        test_reset;
        test_single;
        test_max_hold;
        test_owner_switch;
        test_wraparound;
        test_reset_mid_grant;
        test_idle;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_8.md
# bus_arbiter_8

Round-robin arbiter and sequencer for the shared 16-bit, 8-to-1 operand bus. It accepts up to eight requesters, grants one at a time, and drives the select lines of the 16-bit 8:1 bus mux. It registers the selected word onto the bus with a valid flag. Sits between the register-file/ALU requesters and the shared bus consumer in the ProjectB datapath.

## Interface
Parameters:
- WIDTH, 16, data width of each requester input and of the bus output
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold a grant (≥1)

Ports:
- Clock  in  1  single system clock, rising edge
- ResetN  in  1  reset, asynchronous and active-low
- Req  in  8  request per requester; held high while the requester wants or uses the bus
- In0..In7  in  WIDTH each  requester data words
- Grant  out  8  one-hot grant, registered
- S2, S1, S0  out  1 each  mux select (S2 = MSB) = index of granted requester, registered
- DataOut  out  WIDTH  registered bus word
- DataValid  out  1  DataOut holds a word from a granted requester
- Expired  out  1  one-cycle pulse: grant forcibly withdrawn at MAX_HOLD

## Operation
- States: IDLE, GRANT, TURN.
- IDLE:
  - If Req≠0, choose the first set bit searching (Last+1) mod 8 upward with wrap-around.
  - Next cycle: Grant one-hot at that index, {S2,S1,S0} = index, HoldCnt = 1, state GRANT.
  - If Req=0, stay in IDLE with Grant=0.
- GRANT (owner idx):
  - If Req[idx]=1 and HoldCnt<MAX_HOLD: stay, HoldCnt+1.
  - If Req[idx]=0: go to TURN, Last=idx.
  - If Req[idx]=1 and HoldCnt=MAX_HOLD: go to TURN, Last=idx, Expired=1 for the TURN cycle.
  - Req changes on other bits are ignored while in GRANT.
- TURN:
  - One dead cycle, Grant=0, select lines keep idx.
  - Always returns to IDLE. A TURN→IDLE→GRANT turnaround is 2 cycles with no grant.
- Expired requester keeps Req high: re-competes normally; round-robin puts it last among active requesters.
- DataOut/DataValid: on each edge where the state is GRANT, DataOut ← mux(In0..In7, idx) and DataValid ← 1. Otherwise DataValid ← 0 and DataOut holds its last value.
- HoldCnt width $clog2(MAX_HOLD+1). Never exceeds MAX_HOLD. Cleared in IDLE/TURN.
- Reset (any time, including mid-grant): state IDLE, Grant=0, select=000, Last=7 (requester 0 has top priority first), HoldCnt=0, DataOut=0, DataValid=0, Expired=0. Takes effect immediately and asynchronously.

## Timing
- Req seen in IDLE at edge k → Grant/select valid after edge k+1.
- First DataOut/DataValid after edge k+2.
- Owner drops Req before edge m → Grant=0 after edge m. DataValid falls after edge m+1.
- Max continuous grant = MAX_HOLD cycles. Minimum gap between grants = 2 cycles (TURN, IDLE).
- Outputs are all registered. The only combinational path is In* → mux → DataOut D-input.
- Simultaneous: a requester's Req rising while the owner releases is arbitrated in the following IDLE, not in TURN.

## Structure
- Shared package bus_arb_pkg: state enum (IDLE, GRANT, TURN), NUM_REQ = 8, SEL_W = 3.
- One sub-module, mux_16w_8_to_1: WIDTH-bit combinational 8:1 mux with inputs R..Y, selects S0..S2, and output M. The arbiter instantiates it and drives its selects from the registered select lines.
- Round-robin pick is a function in bus_arb_pkg (Req, Last → index, found).

## Test plan
- Reset, then Req=8'b0000_0001 held 3 cycles, In0=16'h1234 → Grant=01 one cycle after Req, {S2,S1,S0}=000, DataOut=1234 with DataValid=1 for 3 cycles, then TURN.
- Req=8'hFF constant, MAX_HOLD=8 → grants in order 0,1,…,7,0, each lasting 8 cycles, Expired pulses after each, 2-cycle gap between grants.
- Owner 5 active, Req[2] rises mid-grant, Req[5] drops → TURN, IDLE, then Grant=8'b0000_0100, select=010.
- Last=6, Req=8'b0100_0001 → grant goes to 0 (wrap-around), next grant to 6.
- ResetN low mid-grant of requester 3 with DataValid=1 → Grant=0, DataValid=0, DataOut=0, select=000 immediately. After release with Req=8'b0000_1001, requester 0 is granted first.
- Req=0 for 20 cycles → Grant=0, DataValid=0, Expired=0 throughout, state stays IDLE.
